// File: rtl/seq_detector_param_if.sv
// Bundles the serial-detector sample/control inputs and match outputs so the
// source side (master) and the detector (slave) share one port.
interface seq_detector_param_if #(
   parameter int PATTERN_WIDTH = 4,
   parameter int COUNT_WIDTH   = 8
);
   logic                     en;
   logic                     w;
   logic                     load;
   logic [PATTERN_WIDTH-1:0] pattern_in;
   logic                     overlap;
   logic                     z;
   logic                     armed;
   logic [COUNT_WIDTH-1:0]   match_count;

   modport master (
      output en, w, load, pattern_in, overlap,
      input  z, armed, match_count
   );

   modport slave (
      input  en, w, load, pattern_in, overlap,
      output z, armed, match_count
   );
endinterface

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: shifts accepted bits into a history
// register and pulses z when the last PATTERN_WIDTH bits equal the loaded pattern.
module seq_detector_param #(
   parameter int PATTERN_WIDTH = 4,
   parameter int COUNT_WIDTH   = 8
) (
   input logic                clock,
   input logic                reset,
   seq_detector_param_if.slave bus
);
   localparam int FW = $clog2(PATTERN_WIDTH + 1);

   typedef enum logic [1:0] {EMPTY, FILL, ARMED} state_e;

   state_e                   state_q, state_d;
   logic [PATTERN_WIDTH-1:0] pat_q, pat_d;
   logic [PATTERN_WIDTH-1:0] hist_q, hist_d, hist_shift;
   logic [FW-1:0]            fill_q, fill_d;
   logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic                     z_q, z_d;
   logic                     armed_q, armed_d;

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      hist_d     = hist_q;
      fill_d     = fill_q;
      cnt_d      = cnt_q;
      z_d        = 1'b0;
      hist_shift = {hist_q[PATTERN_WIDTH-2:0], bus.w};
      if (bus.load) begin
         // load wins over a same-cycle sample, so a match never spans a load
         state_d = FILL;
         pat_d   = bus.pattern_in;
         hist_d  = '0;
         fill_d  = '0;
         cnt_d   = '0;
      end else if (bus.en && state_q != EMPTY) begin
         hist_d = hist_shift;
         if (state_q == FILL) begin
            fill_d = fill_q + FW'(1);
            if (fill_d == FW'(PATTERN_WIDTH)) state_d = ARMED;
         end
         if (state_d == ARMED && hist_shift == pat_q) begin
            z_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
            // non-overlapping: the next match needs a full fresh window
            if (!bus.overlap) begin
               state_d = FILL;
               fill_d  = '0;
               hist_d  = '0;
            end
         end
      end
      armed_d = (state_d == ARMED);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= EMPTY;
         pat_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         z_q     <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         z_q     <= z_d;
         armed_q <= armed_d;
      end
   end

   assign bus.z           = z_q;
   assign bus.armed       = armed_q;
   assign bus.match_count = cnt_q;
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial pattern detector: samples a one-bit input stream on enabled clock edges and pulses a registered match flag whenever the last `PATTERN_WIDTH` bits equal a run-time programmable pattern. It generalises the fixed-sequence Moore detector used in the lab FSM designs. It adds a programmable pattern, overlapping and non-overlapping modes, a sample enable and a saturating match counter. It sits between a serial bit source (shift register or debounced input) and the display/counter logic.

## Interface
- `PATTERN_WIDTH`, 4, number of bits in the pattern (legal range 2..16).
- `COUNT_WIDTH`, 8, width of the match counter.
- `clock`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (block is in reset while `reset`=0).
- `en`  in  1  sample enable; `w` is consumed only on edges where `en`=1.
- `w`  in  1  serial data bit.
- `load`  in  1  synchronous pattern load strobe.
- `pattern_in`  in  `PATTERN_WIDTH`  pattern to load; bit `PATTERN_WIDTH-1` is the first bit received and bit 0 is the last.
- `overlap`  in  1  mode: 1 = overlapping matches allowed, 0 = history restarts after a match.
- `z`  out  1  registered match pulse.
- `armed`  out  1  high while in state ARMED.
- `match_count`  out  `COUNT_WIDTH`  number of matches since the last reset or load; saturates at all-ones.

## Operation
- Internal registers:
  - pattern register `pat`;
  - history shift register `hist` (`PATTERN_WIDTH` bits), which shifts left on every accepted sample: `hist <= {hist[PATTERN_WIDTH-2:0], w}`;
  - fill counter `fill`, width clog2(`PATTERN_WIDTH`+1), which saturates at `PATTERN_WIDTH`.
- States:
  - EMPTY: no pattern loaded. Samples are ignored and `z` is never asserted.
  - FILL: accepted samples shift into `hist` and increment `fill`. The state moves to ARMED on the edge where `fill` becomes `PATTERN_WIDTH`. The comparison is also performed on that edge, using the post-shift history.
  - ARMED: on each accepted sample, `match` = (post-shift `hist` == `pat`).
- Transitions:
  - Any state with `load`=1 goes to FILL: `pat <= pattern_in`, `hist <= 0`, `fill <= 0`, `match_count <= 0`, `z <= 0`.
  - FILL to ARMED as described above.
  - ARMED on a match with `overlap`=1 stays in ARMED.
  - ARMED on a match with `overlap`=0 goes to FILL with `fill <= 0` and `hist <= 0`, so the next match requires `PATTERN_WIDTH` fresh bits.
- On a match, `z <= 1` and `match_count` increments unless it is all-ones.
- `z <= 0` on every edge that does not produce a match, including edges with `en`=0.
- `overlap` is sampled on the matching edge itself; changing it between matches is legal.

## Timing
- Reset (`reset`=0, asynchronous): state EMPTY, `pat`=0, `hist`=0, `fill`=0, `z`=0, `armed`=0, `match_count`=0.
- Deassertion of `reset` takes effect at the next rising edge of `clock`.
- Latency: `z` goes high for exactly one cycle, starting at the rising edge that samples the completing bit. It is visible one clock period after that bit was presented.
- `match_count` updates on the same edge that `z` rises.
- Back-to-back matches in overlap mode (for example an all-ones pattern on an all-ones stream) hold `z` high on consecutive cycles, and `match_count` increments every cycle.
- `en`=0 freezes `hist`, `fill`, state and `match_count`, and forces `z` low on the next edge.
- Simultaneous `load` and `en`: `load` wins and the `w` bit of that cycle is discarded.
- `load` in the same cycle as a would-be match: no match is recorded and `z`=0.
- Reset mid-sequence discards any partial history; a match never spans a reset or a load.
- `armed` is registered and is high in every cycle in which the state is ARMED.
- `match_count` at all-ones stays at all-ones while `z` still pulses.

## Test plan
- Reset and idle: with `reset`=0 then released and no load, drive `en`=1 with 20 random bits. Required: `z`=0, `armed`=0 and `match_count`=0 throughout.
- Basic detect with N=4: load 4'b1000, then drive `w`=1,0,0,0 with `en`=1. Required: `armed` rises after the 4th bit, `z`=1 for one cycle on the 4th sampled bit, `match_count`=1.
- Overlap mode: load 4'b0110, `overlap`=1, stream 0,1,1,0,1,1,0. Required: `z` pulses on the 4th and 7th bits, `match_count`=2.
  - Same stream with `overlap`=0. Required: one pulse on the 4th bit only, `match_count`=1.
- Enable gaps: with pattern 4'b1000, drive 1,0,0,0 with `en`=0 cycles inserted between bits. Required: the match on the 4th accepted bit is unaffected by the gaps.
  - With `en`=0 held for 3 cycles after the match. Required: `z` returns to 0 and `match_count` holds at 1.
- Reload and reset mid-operation: after 1,0,0 of pattern 4'b1000, assert `load` with 4'b1111 in the same cycle as `en`=1.
  - Required: the bit is discarded, `match_count`=0, `armed`=0, and `z` first pulses on the 4th subsequent 1.
  - Assert `reset`=0 asynchronously mid-cycle. Required: all outputs go to 0 immediately and the state returns to EMPTY.
- Saturation: with `COUNT_WIDTH`=3, pattern 2'b11 (N=2), `overlap`=1, drive 12 consecutive 1s.
  - Required: `z` is high from the 2nd bit onward every cycle.
  - Required: `match_count` reaches 7 and stays at 7.
